mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the EX stage, beside the ALU. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations into private HI/LO registers, handles MTHI/MTLO writes and returns HI/LO for MFHI/MFLO. It raises `Busy` so the hazard unit can stall later MDU instructions in D. It honours the exception/interrupt request line, so a flushed instruction never changes HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: Busy-high cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: Busy-high cycles for DIV/DIVU.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `Start`  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU; qualified by `MDUOp`.
- `MDUOp`  in  4  operation code:
  - 0000 none
  - 0001 MULT
  - 0010 MULTU
  - 0011 DIV
  - 0100 DIVU
  - 0101 MFHI
  - 0110 MFLO
  - 0111 MTHI
  - 1000 MTLO
  - other codes: none
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `Req`  in  1  exception/interrupt flush of the EX instruction; blocks start and MT writes this cycle.
- `Busy`  out  1  operation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `MDU_Result`  out  32  combinational read value: HI for MFHI, LO for MFLO, else 0.

## Operation
- State:
  - `HI`, `LO`
  - `Busy`
  - down-counter `Cnt[3:0]`
  - pending registers `HI_tmp`, `LO_tmp`
  - `Upd`: set when the result must be committed
- Accept condition: `Start && !Busy && !Req && MDUOp in {0001..0100}`. On the accepting edge:
  - compute the result into `HI_tmp`/`LO_tmp`;
  - load `Cnt` with the operation's cycle count;
  - set `Busy`.
- MULT: {HI,LO} = 64-bit signed A*B.
- MULTU: {HI,LO} = 64-bit unsigned A*B.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, unsigned remainder in HI.
- Divide by zero (B=0, DIV or DIVU):
  - runs the full DIV_CYCLES with Busy high;
  - HI/LO stay unchanged (`Upd`=0).
- While Busy, each edge decrements `Cnt`. On the edge where `Cnt`==1:
  - `Busy` is cleared;
  - if `Upd`, HI/LO take `HI_tmp`/`LO_tmp`.
- MTHI/MTLO: when `!Busy && !Req`, HI (or LO) is loaded with A at the edge.
- Ignored requests (no state change):
  - MT while Busy;
  - Start while Busy;
  - Start or MT with Req=1;
  - unknown opcode.
- MFHI/MFLO are purely combinational from the current HI/LO. They are valid only when !Busy; the hazard unit guarantees this.
- Hazard contract: D stalls while `Busy || (Start && mult/div op)` if the D instruction uses the MDU.

## Timing
- Reset: `Busy`=0, `HI`=0, `LO`=0, `Cnt`=0, `Upd`=0, pending registers=0. `MDU_Result`=0 unless MFHI/MFLO is selected.
- Reset while busy: the operation is abandoned and the reset values apply in the next cycle.
- Reset has priority over every other event.
- Accept at edge t0:
  - Busy is high in cycles t0+1 … t0+N (N = MULT_CYCLES or DIV_CYCLES);
  - the new HI/LO are visible from cycle t0+N+1, the same cycle Busy is first low.
- A new Start is accepted in the cycle Busy returns low, i.e. back-to-back with one cycle gap minimum.
- MT write at edge t: HI/LO show the new value from cycle t+1.
- `MDU_Result` has zero latency.
- `Cnt` never wraps: it is loaded only on accept and is held at 0 when idle.

## Test plan
1. Reset, then MULT with A=0xFFFFFFFF, B=2 → Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands as MULTU → HI=0x00000001, LO=0xFFFFFFFE.
2. DIV with A=0xFFFFFFF9 (-7), B=2 → Busy high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=2 → LO=3, HI=1. DIV with 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
3. MTHI A=0x1234, then MTLO A=0x5678, then DIV B=0 → Busy for 10 cycles; afterwards HI=0x1234, LO=0x5678. MFHI/MFLO return these values combinationally.
4. Start MULT with Req=1 → Busy stays 0, HI/LO unchanged. MTLO with Req=1 → LO unchanged.
5. Start DIV, then in busy cycle 3 present a MULT Start and an MTHI → both ignored; the DIV result commits at cycle 10. A MULT Start in the cycle Busy falls → accepted.
6. Assert reset during busy cycle 4 of a MULT → next cycle Busy=0, HI=LO=0, and no late commit occurs afterwards.

Source files
------------

// File: rtl/mdu_if.sv
// mdu_if: EX-stage multiply/divide request and HI/LO result bundle.
interface mdu_if;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_Result;
    modport master (output Start, MDUOp, A, B, Req, input Busy, HI, LO, MDU_Result);
    modport slave  (input Start, MDUOp, A, B, Req, output Busy, HI, LO, MDU_Result);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO and MFHI/MFLO.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    logic        busy, upd;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, hi_tmp, lo_tmp;
    logic        is_mul, is_div, accept;
    logic [31:0] abs_a, abs_b, sdiv, udiv, sq, sr;
    logic [63:0] smul, umul, res;
    assign is_mul = bus.MDUOp == 4'd1 || bus.MDUOp == 4'd2;
    assign is_div = bus.MDUOp == 4'd3 || bus.MDUOp == 4'd4;
    assign accept = bus.Start && !busy && !bus.Req && (is_mul || is_div);
    assign smul = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign umul = {32'd0, bus.A} * {32'd0, bus.B};
    // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 cleanly.
    assign abs_a = bus.A[31] ? -bus.A : bus.A;
    assign abs_b = bus.B[31] ? -bus.B : bus.B;
    assign sdiv  = bus.B == 32'd0 ? 32'd1 : abs_b;
    assign udiv  = bus.B == 32'd0 ? 32'd1 : bus.B;
    assign sq    = abs_a / sdiv;
    assign sr    = abs_a % sdiv;
    assign res   = bus.MDUOp == 4'd1 ? smul :
                   bus.MDUOp == 4'd2 ? umul :
                   bus.MDUOp == 4'd3 ? {bus.A[31] ? -sr : sr, (bus.A[31] ^ bus.B[31]) ? -sq : sq} :
                   {bus.A % udiv, bus.A / udiv};
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            upd    <= 1'b0;
            cnt    <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy <= 1'b0;
                upd  <= 1'b0;
                if (upd) begin
                    hi <= hi_tmp;
                    lo <= lo_tmp;
                end
            end
        end else if (accept) begin
            hi_tmp <= res[63:32];
            lo_tmp <= res[31:0];
            cnt    <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy   <= 1'b1;
            upd    <= !(is_div && bus.B == 32'd0);
        end else if (!bus.Req && bus.MDUOp == 4'd7) begin
            hi <= bus.A;
        end else if (!bus.Req && bus.MDUOp == 4'd8) begin
            lo <= bus.A;
        end
    end
    assign bus.Busy       = busy;
    assign bus.HI         = hi;
    assign bus.LO         = lo;
    assign bus.MDU_Result = bus.MDUOp == 4'd5 ? hi : bus.MDUOp == 4'd6 ? lo : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors; expected HI/LO pushed at issue, checked by a monitor on Busy falling.
module tb_mdu;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    logic [63:0] exp_q[$];
    logic prev_busy = 1'b0;
    mdu_if bus();
    mdu dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    always @(negedge clk) begin
        if (prev_busy && bus.Busy === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL commit: unexpected completion HI=%h LO=%h", bus.HI, bus.LO);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("commit_hi", bus.HI, e[63:32]);
                check("commit_lo", bus.LO, e[31:0]);
            end
        end
        prev_busy = bus.Busy === 1'b1;
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        bus.Start = st;
        bus.MDUOp = op;
        bus.A = a;
        bus.B = b;
        bus.Req = rq;
        step();
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.Req = 1'b0;
    endtask
    task automatic wait_busy(input int n, input string name);
        int c = 0;
        for (int i = 0; i < 30; i++) begin
            if (!bus.Busy) break;
            c++;
            step();
        end
        check(name, 32'(c), 32'(n));
    endtask
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int n, input string name);
        exp_q.push_back({eh, el});
        drive(1'b1, op, a, b, 1'b0);
        wait_busy(n, name);
    endtask
    initial begin
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        bus.Req = 1'b0;
        reset = 1'b1;
        step();
        step();
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_res", bus.MDU_Result, 32'd0);
        reset = 1'b0;
        step();
        run(4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult_cycles");
        run(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, "multu_cycles");
        run(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_cycles");
        run(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu_cycles");
        run(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, "div_ovf_cycles");
        drive(1'b0, 4'd7, 32'h1234, 32'd0, 1'b0);
        check("mthi", bus.HI, 32'h1234);
        drive(1'b0, 4'd8, 32'h5678, 32'd0, 1'b0);
        check("mtlo", bus.LO, 32'h5678);
        run(4'd3, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, "div0_cycles");
        bus.MDUOp = 4'd5;
        #1 check("mfhi", bus.MDU_Result, 32'h1234);
        bus.MDUOp = 4'd6;
        #1 check("mflo", bus.MDU_Result, 32'h5678);
        bus.MDUOp = 4'd9;
        #1 check("mf_unknown", bus.MDU_Result, 32'd0);
        bus.MDUOp = 4'd0;
        step();
        drive(1'b1, 4'd1, 32'd3, 32'd3, 1'b1);
        check("req_start_busy", {31'd0, bus.Busy}, 32'd0);
        check("req_start_lo", bus.LO, 32'h5678);
        drive(1'b0, 4'd8, 32'hDEAD, 32'd0, 1'b1);
        check("req_mtlo", bus.LO, 32'h5678);
        drive(1'b0, 4'd7, 32'hBEEF, 32'd0, 1'b1);
        check("req_mthi", bus.HI, 32'h1234);
        exp_q.push_back({32'd2, 32'd14});
        drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        step();
        step();
        drive(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
        drive(1'b0, 4'd7, 32'hAAAA, 32'd0, 1'b0);
        check("busy_mthi_ign", bus.HI, 32'h1234);
        repeat (5) step();
        check("div_busy_c10", {31'd0, bus.Busy}, 32'd1);
        step();
        check("div_busy_c11", {31'd0, bus.Busy}, 32'd0);
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF4});
        drive(1'b1, 4'd1, 32'd3, 32'hFFFFFFFC, 1'b0);
        wait_busy(5, "b2b_mult_cycles");
        exp_q.push_back({32'd0, 32'd0});
        drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstb_busy", {31'd0, bus.Busy}, 32'd0);
        check("rstb_hi", bus.HI, 32'd0);
        check("rstb_lo", bus.LO, 32'd0);
        repeat (8) step();
        check("no_late_lo", bus.LO, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
